// File: rtl/insn_decode_stage.sv
// Instruction decode stage: field extraction, immediate extension, register-file read
// with same-cycle writeback bypass, and a per-register busy scoreboard that stalls RAW hazards.
module insn_decode_stage #(
  parameter int LEN_INSN    = 32,
  parameter int LEN_OPECODE = 7,
  parameter int LEN_REGNO   = 4,
  parameter int LEN_REG     = 32,
  parameter int LEN_IMM     = 16,
  parameter int LEN_IMM_EX  = 32,
  parameter int LEN_CC      = 4,
  parameter logic [LEN_OPECODE-1:0] OPECODE_CMP = 7'b010_0000,
  parameter logic [LEN_OPECODE-1:0] OPECODE_ST  = 7'b010_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN_INSN-1:0]    insn,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_OPECODE-1:0] opecode_o,
  output logic                   immf_o,
  output logic [LEN_REGNO-1:0]   rd_o,
  output logic [LEN_REGNO-1:0]   rs_o,
  output logic [LEN_CC-1:0]      cc_o,
  output logic [LEN_IMM_EX-1:0]  imm_o,
  output logic [LEN_REG-1:0]     data_rd,
  output logic [LEN_REG-1:0]     data_rs,
  input  logic                   wb_en,
  input  logic [LEN_REGNO-1:0]   wb_rd,
  input  logic [LEN_REG-1:0]     wb_data
);

  localparam int NUM_REGS = 2 ** LEN_REGNO;
  localparam int POS_IMMF = LEN_INSN - LEN_OPECODE - 1;
  localparam int POS_RD   = POS_IMMF - 1;
  localparam int POS_RS   = POS_RD - LEN_REGNO;

  logic [LEN_OPECODE-1:0] dec_opecode;
  logic                   dec_immf;
  logic [LEN_REGNO-1:0]   dec_rd;
  logic [LEN_REGNO-1:0]   dec_rs;
  logic [LEN_IMM-1:0]     dec_imm;
  logic [LEN_CC-1:0]      dec_cc;
  logic                   dec_is_wb;
  logic [LEN_IMM_EX-1:0]  dec_imm_ex;

  assign dec_opecode = insn[LEN_INSN-1 -: LEN_OPECODE];
  assign dec_immf    = insn[POS_IMMF];
  assign dec_rd      = insn[POS_RD -: LEN_REGNO];
  assign dec_rs      = insn[POS_RS -: LEN_REGNO];
  assign dec_imm     = insn[LEN_IMM-1:0];
  assign dec_cc      = insn[LEN_IMM-1 -: LEN_CC];
  assign dec_is_wb   = (dec_opecode != OPECODE_CMP) && (dec_opecode != OPECODE_ST);

  // Extension class is selected by the top four opecode bits.
  always_comb begin
    dec_imm_ex = '0;
    if (dec_immf) begin
      case (dec_opecode[LEN_OPECODE-1 -: 4])
        4'b0000, 4'b0011: dec_imm_ex = LEN_IMM_EX'($signed(dec_imm));
        4'b0001:          dec_imm_ex = LEN_IMM_EX'(dec_imm[4:0]);
        default:          dec_imm_ex = LEN_IMM_EX'(dec_imm);
      endcase
    end
  end

  logic [LEN_OPECODE-1:0] opecode_reg;
  logic                   immf_reg;
  logic [LEN_REGNO-1:0]   rd_reg;
  logic [LEN_REGNO-1:0]   rs_reg;
  logic [LEN_CC-1:0]      cc_reg;
  logic [LEN_IMM_EX-1:0]  imm_reg;
  logic [LEN_REG-1:0]     data_rd_reg;
  logic [LEN_REG-1:0]     data_rs_reg;
  logic                   out_valid_reg;
  logic                   is_wb_reg;

  logic [LEN_REG-1:0]  regfile [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;

  logic wb_hit_rd;
  logic wb_hit_rs;
  logic hazard;
  logic accept;
  logic [LEN_REG-1:0] rd_value;
  logic [LEN_REG-1:0] rs_value;

  assign wb_hit_rd = wb_en && (wb_rd == dec_rd);
  assign wb_hit_rs = wb_en && (wb_rd == dec_rs);
  // A busy source is fine when its producer is writing back on this very edge.
  assign hazard    = (busy_vec[dec_rd] && !wb_hit_rd)
                   || (!dec_immf && busy_vec[dec_rs] && !wb_hit_rs);
  assign in_ready  = !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign rd_value  = wb_hit_rd ? wb_data : regfile[dec_rd];
  assign rs_value  = wb_hit_rs ? wb_data : regfile[dec_rs];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [LEN_REGNO-1:0] IDX = LEN_REGNO'(gi);
      logic [LEN_REG-1:0] value_reg;
      logic               busy_reg;
      logic               set_busy;
      logic               clr_wb;
      logic               clr_flush;

      assign set_busy  = accept && dec_is_wb && (dec_rd == IDX);
      assign clr_wb    = wb_en && (wb_rd == IDX);
      assign clr_flush = flush && out_valid_reg && is_wb_reg && (rd_reg == IDX);

      always_ff @(posedge clk) begin
        if (rst) begin
          value_reg <= '0;
          busy_reg  <= 1'b0;
        end else begin
          if (clr_wb)
            value_reg <= wb_data;
          // A new issue claiming the register wins over any clear on the same edge.
          if (set_busy)
            busy_reg <= 1'b1;
          else if (clr_wb || clr_flush)
            busy_reg <= 1'b0;
        end
      end

      assign regfile[gi]  = value_reg;
      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      is_wb_reg     <= 1'b0;
      opecode_reg   <= '0;
      immf_reg      <= 1'b0;
      rd_reg        <= '0;
      rs_reg        <= '0;
      cc_reg        <= '0;
      imm_reg       <= '0;
      data_rd_reg   <= '0;
      data_rs_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      is_wb_reg     <= dec_is_wb;
      opecode_reg   <= dec_opecode;
      immf_reg      <= dec_immf;
      rd_reg        <= dec_rd;
      rs_reg        <= dec_rs;
      cc_reg        <= dec_cc;
      imm_reg       <= dec_imm_ex;
      data_rd_reg   <= rd_value;
      data_rs_reg   <= rs_value;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign opecode_o = opecode_reg;
  assign immf_o    = immf_reg;
  assign rd_o      = rd_reg;
  assign rs_o      = rs_reg;
  assign cc_o      = cc_reg;
  assign imm_o     = imm_reg;
  assign data_rd   = data_rd_reg;
  assign data_rs   = data_rs_reg;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed bench for insn_decode_stage: decode vector table plus hazard, backpressure,
// flush and same-edge set/clear sequences.
module tb_insn_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opecode_o;
  logic        immf_o;
  logic [3:0]  rd_o;
  logic [3:0]  rs_o;
  logic [3:0]  cc_o;
  logic [31:0] imm_o;
  logic [31:0] data_rd;
  logic [31:0] data_rs;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  insn_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .insn(insn), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .opecode_o(opecode_o), .immf_o(immf_o), .rd_o(rd_o), .rs_o(rs_o),
    .cc_o(cc_o), .imm_o(imm_o), .data_rd(data_rd), .data_rs(data_rs),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    logic [31:0] insn;
    logic [6:0]  op;
    logic        immf;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  cc;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0312_8001, 7'h01, 1'b1, 4'h1, 4'h2, 4'h8, 32'hFFFF_8001};
    vecs[1] = '{32'h1134_FFFF, 7'h08, 1'b1, 4'h3, 4'h4, 4'hF, 32'h0000_001F};
    vecs[2] = '{32'h4556_FFFF, 7'h22, 1'b1, 4'h5, 4'h6, 4'hF, 32'h0000_FFFF};
    vecs[3] = '{32'h0278_8001, 7'h01, 1'b0, 4'h7, 4'h8, 4'h8, 32'h0000_0000};
    vecs[4] = '{32'h359A_8123, 7'h1A, 1'b1, 4'h9, 4'hA, 4'h8, 32'hFFFF_8123};
    vecs[5] = '{32'h11BC_0035, 7'h08, 1'b1, 4'hB, 4'hC, 4'h0, 32'h0000_0015};
    vecs[6] = '{32'h35DE_7FFF, 7'h1A, 1'b1, 4'hD, 4'hE, 4'h7, 32'h0000_7FFF};
    vecs[7] = '{32'hE1F0_8000, 7'h70, 1'b1, 4'hF, 4'h0, 4'h8, 32'h0000_8000};

    rst = 1'b1; in_valid = 1'b0; insn = '0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;

    // Reset state
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_opecode", {25'b0, opecode_o}, 32'h0);
    chk("rst_imm", imm_o, 32'h0);
    chk("rst_data_rd", data_rd, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b0;
    in_valid = 1'b1; insn = 32'h0035_0000;
    step();
    chk("rst_rd3", data_rd, 32'h0);
    chk("rst_rs5", data_rs, 32'h0);
    in_valid = 1'b0; wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h0;
    step();
    wb_en = 1'b0;

    // Decode table
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; insn = vecs[i].insn;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_op", i), {25'b0, opecode_o}, {25'b0, vecs[i].op});
      chk($sformatf("v%0d_immf", i), {31'b0, immf_o}, {31'b0, vecs[i].immf});
      chk($sformatf("v%0d_rd", i), {28'b0, rd_o}, {28'b0, vecs[i].rd});
      chk($sformatf("v%0d_rs", i), {28'b0, rs_o}, {28'b0, vecs[i].rs});
      chk($sformatf("v%0d_cc", i), {28'b0, cc_o}, {28'b0, vecs[i].cc});
      chk($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
      in_valid = 1'b0; wb_en = 1'b1; wb_rd = vecs[i].rd; wb_data = 32'h0;
      step();
      wb_en = 1'b0;
    end

    // RAW stall on r2 released by writeback with bypass
    in_valid = 1'b1; insn = 32'h0120_0000;
    step();
    insn = 32'h0012_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("raw_stall%0d", c), {31'b0, in_ready}, 32'h0);
      step();
    end
    wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("raw_release", {31'b0, in_ready}, 32'h1);
    step();
    chk("raw_valid", {31'b0, out_valid}, 32'h1);
    chk("raw_bypass_rs", data_rs, 32'hDEAD_BEEF);
    chk("raw_rd1", data_rd, 32'h0);
    in_valid = 1'b0; wb_rd = 4'd1; wb_data = 32'h1111_0001;
    step();
    wb_en = 1'b0;
    in_valid = 1'b1; insn = 32'h0021_0000;
    #1;
    chk("rf_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("rf_data_rd_r2", data_rd, 32'hDEAD_BEEF);
    chk("rf_data_rs_r1", data_rs, 32'h1111_0001);
    in_valid = 1'b0; wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'hDEAD_BEEF;
    step();
    wb_en = 1'b0;

    // CMP leaves r4 free, following ST reading r4 goes back-to-back
    in_valid = 1'b1; insn = 32'h4140_0000;
    #1;
    chk("cmp_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    insn = 32'h4244_0000;
    #1;
    chk("cmp_no_stall", {31'b0, in_ready}, 32'h1);
    step();
    chk("st_valid", {31'b0, out_valid}, 32'h1);
    chk("st_op", {25'b0, opecode_o}, 32'h21);
    chk("st_rd", {28'b0, rd_o}, 32'h4);
    in_valid = 1'b0;
    step();

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; insn = 32'h0180_0000;
    step();
    insn = 32'h4190_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_in_ready%0d", c), {31'b0, in_ready}, 32'h0);
      chk($sformatf("bp_valid%0d", c), {31'b0, out_valid}, 32'h1);
      chk($sformatf("bp_rd%0d", c), {28'b0, rd_o}, 32'h8);
      chk($sformatf("bp_op%0d", c), {25'b0, opecode_o}, 32'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_next_rd", {28'b0, rd_o}, 32'h9);
    chk("bp_next_op", {25'b0, opecode_o}, 32'h20);
    in_valid = 1'b0; wb_en = 1'b1; wb_rd = 4'd8; wb_data = 32'h0;
    step();
    wb_en = 1'b0;

    // Flush while holding a write to r6
    out_ready = 1'b0; in_valid = 1'b1; insn = 32'h0160_0000;
    step();
    insn = 32'h4266_0000; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    #1;
    chk("flush_r6_free", {31'b0, in_ready}, 32'h1);
    step();
    chk("flush_reader_valid", {31'b0, out_valid}, 32'h1);
    chk("flush_reader_rd", {28'b0, rd_o}, 32'h6);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Same-edge clear and set of r7: set wins
    in_valid = 1'b1; insn = 32'h0170_0000;
    step();
    #1;
    chk("r7_busy_stall", {31'b0, in_ready}, 32'h0);
    wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h7777_0007;
    #1;
    chk("r7_wb_release", {31'b0, in_ready}, 32'h1);
    step();
    wb_en = 1'b0;
    chk("r7_bypass_rd", data_rd, 32'h7777_0007);
    insn = 32'h4170_0000;
    #1;
    chk("r7_set_wins", {31'b0, in_ready}, 32'h0);

    // Reset mid-stall discards everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_rd", {28'b0, rd_o}, 32'h0);
    #1;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("mid_rst_rf_cleared", data_rd, 32'h0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage with a valid/ready handshake on both sides.
- Extracts instruction fields and extends the immediate. Reads operands from an internal register file.
- Tracks pending writebacks in a per-register busy scoreboard, stalls on hazards, and forwards same-cycle writeback data.
- Sits between instruction fetch and execute; execute's writeback port feeds back into it.

Parameters:
LEN_INSN 32 instruction width
LEN_OPECODE 7 opecode width
LEN_REGNO 4 register-number width; register file has 2**LEN_REGNO entries
LEN_REG 32 register/data width
LEN_IMM 16 raw immediate width
LEN_IMM_EX 32 extended immediate width (>= LEN_IMM)
LEN_CC 4 condition-code width (<= LEN_IMM)
OPECODE_CMP 7'b010_0000 opecode with no register writeback
OPECODE_ST 7'b010_0001 opecode with no register writeback

Ports:
clk input 1 clock
rst input 1 synchronous active-high reset
in_valid input 1 insn valid
in_ready output 1 stage accepts insn this cycle
insn input LEN_INSN instruction
flush input 1 discard held output and refuse input
out_valid output 1 decoded bundle valid
out_ready input 1 downstream accepts bundle
opecode_o output LEN_OPECODE opecode
immf_o output 1 immediate flag
rd_o output LEN_REGNO destination/first source register
rs_o output LEN_REGNO second source register
cc_o output LEN_CC condition code
imm_o output LEN_IMM_EX extended immediate
data_rd output LEN_REG value of rd
data_rs output LEN_REG value of rs
wb_en input 1 writeback strobe
wb_rd input LEN_REGNO writeback register
wb_data input LEN_REG writeback value

Behaviour:
- Field layout, MSB first:
  - opecode = insn[LEN_INSN-1 -: LEN_OPECODE]
  - immf = next bit
  - rd = next LEN_REGNO bits
  - rs = next LEN_REGNO bits
  - imm = insn[LEN_IMM-1:0]
  - cc = insn[LEN_IMM-1 -: LEN_CC] (overlays the top of imm)
- Field constraint: LEN_OPECODE+1+2*LEN_REGNO+LEN_IMM <= LEN_INSN.
- is_wb = 0 iff opecode is OPECODE_CMP or OPECODE_ST.
- Immediate extension:
  - immf=0 -> imm_o=0.
  - Otherwise, by opecode[6:3]:
    - 0000 -> sign-extend imm
    - 0001 -> zero-extend imm[4:0]
    - 0011 -> sign-extend imm
    - any other -> zero-extend imm
- Hazard:
  - rd is always a source.
  - rs is a source only when immf=0.
  - hazard = source register busy and not cleared by the same-cycle writeback (wb_en && wb_rd==reg).
- in_ready = !flush && !hazard && (!out_valid || out_ready). This is combinational.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - All outputs load and out_valid=1.
  - data_rd/data_rs take wb_data if wb_en && wb_rd matches (bypass); otherwise the register-file value.
  - If is_wb, busy[rd] <= 1.
- out_valid && out_ready with no accept -> out_valid <= 0. Other outputs hold.
- Writeback on wb_en:
  - regfile[wb_rd] <= wb_data at the edge and busy[wb_rd] <= 0.
  - Same edge sets and clears the same register -> set wins.
  - Writeback to a non-busy register is legal; it updates data only.
- flush:
  - out_valid <= 0, and no accept that cycle.
  - If the held bundle was valid with is_wb, its busy[rd] is cleared unless a new set targets it.
  - Flush overrides out_ready.
- Output stability: while out_valid && !out_ready, all outputs are held stable.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 insn/cycle when there are no hazards.
- Reset:
  - out_valid=0; all output fields=0.
  - Every register-file entry=0 and every busy bit=0.
  - in_ready follows its equation (=1 after reset).
  - Reset mid-stall discards all state.

Test Plan:
- Reset: assert rst 2 cycles -> out_valid=0, all regs 0, in_ready=1; decode of rd=3, rs=5, immf=0 gives data_rd=data_rs=0.
- Immediate extension:
  - immf=1, opecode 7'b000_0001, imm=16'h8001 -> imm_o=32'hFFFF_8001.
  - opecode 7'b000_1000, imm=16'hFFFF -> imm_o=32'h0000_001F.
  - opecode 7'b010_0010 -> 32'h0000_FFFF.
  - immf=0 -> imm_o=0.
- RAW stall:
  - Issue write to r2 (opecode 0); next insn reads rs=r2 with immf=0 -> in_ready=0 until wb_en, wb_rd=2, wb_data=32'hDEAD_BEEF.
  - That cycle it is accepted, with data_rs=32'hDEAD_BEEF (bypass).
- CMP/ST: issue OPECODE_CMP with rd=4 -> busy[4] stays 0; a following read of r4 is accepted back-to-back with no stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next insn accepted the same cycle.
- Flush/simultaneous:
  - flush while holding a write to r6 -> out_valid=0 and busy[6] cleared; a reader of r6 is then accepted.
  - wb_rd=7 clear on the same edge as a new issue writing r7 -> busy[7]=1.
